sequence_player: RTL and testbench

- Parametrised successor to the fixed 4-LED blinker: plays back a stored Simon sequence of configurable length across N_CH lamps.
- Sits between the game FSM (start/abort/len/tempo in; busy/done out) and the sequence memory (rd_addr out, rd_data in).
- Adds beyond the blinker: lead-in gap, runtime tempo scaling, abort, start/done handshake, out-of-range handling.
- Drives led_out to top level.

---
 rtl/simon_pkg.sv | 24 ++
 rtl/sequence_player_if.sv | 36 +++
 rtl/chan_decoder.sv | 27 ++
 rtl/sequence_player.sv | 169 ++++++++++++++++
 tb/tb_sequence_player.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Package : simon_pkg
// Brief   : Shared types and width helpers for the Simon sequence player.
// Rev     : 1.0
// ============================================================================
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    ON   = 2'd2,
    OFF  = 2'd3
  } player_state_t;

  typedef logic [1:0] tempo_t;

  // Index width for a range of v values; a single-entry range still needs one bit.
  function automatic int clog2w(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_player_if.sv
`default_nettype none
// ============================================================================
// Interface : sequence_player_if
// Brief     : Game-FSM handshake, sequence-memory read port and lamp drive.
// Rev       : 1.0
// ============================================================================
interface sequence_player_if #(
  parameter int ADDR_W = 4,
  parameter int CH_W   = 2,
  parameter int LED_W  = 10
);
  import simon_pkg::*;

  logic              start_i;
  logic              abort_i;
  logic [ADDR_W:0]   len_i;
  tempo_t            tempo_i;
  logic [CH_W-1:0]   rd_data_i;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [LED_W-1:0]  led_out_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   step_o;

  modport master (
    output start_i, abort_i, len_i, tempo_i, rd_data_i,
    input  rd_addr_o, led_out_o, busy_o, done_o, step_o
  );

  modport slave (
    input  start_i, abort_i, len_i, tempo_i, rd_data_i,
    output rd_addr_o, led_out_o, busy_o, done_o, step_o
  );

endinterface
`default_nettype wire

// File: rtl/chan_decoder.sv
`default_nettype none
// ============================================================================
// Module : chan_decoder
// Brief  : Channel index to one-hot lamp vector; out-of-range index gives zero.
// Rev    : 1.0
// ============================================================================
module chan_decoder
  import simon_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int LED_W = 10,
  parameter int CH_W  = clog2w(N_CH)
) (
  input  logic [CH_W-1:0]  idx_i,
  output logic [LED_W-1:0] onehot_o
);

  for (genvar g = 0; g < LED_W; g++) begin : g_bit
    if (g < N_CH) begin : g_lamp
      assign onehot_o[g] = (idx_i == CH_W'(g));
    end else begin : g_dark
      assign onehot_o[g] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sequence_player.sv
`default_nettype none
// ============================================================================
// Module : sequence_player
// Brief  : Plays a stored Simon sequence across N_CH lamps with lead-in gap,
//          tempo scaling, abort and start/done handshake.
// Rev    : 1.0
// ============================================================================
module sequence_player
  import simon_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MAX_LEN = 16,
  parameter int LED_W   = 10,
  parameter int ON_CYC  = 5_000_000,
  parameter int OFF_CYC = 5_000_000
) (
  input  logic               clk,
  input  logic               reset,
  sequence_player_if.slave   bus_io
);

  localparam int c_addr_w  = clog2w(MAX_LEN);
  localparam int c_ch_w    = clog2w(N_CH);
  localparam int c_max_cyc = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int c_cnt_w   = $clog2(c_max_cyc) + 1;

  localparam logic [c_cnt_w-1:0]  c_on_base  = c_cnt_w'(ON_CYC);
  localparam logic [c_cnt_w-1:0]  c_off_base = c_cnt_w'(OFF_CYC);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_addr_w-1:0] c_idx_one  = c_addr_w'(1);
  localparam logic [c_addr_w:0]   c_step_one = (c_addr_w + 1)'(1);
  localparam logic [c_addr_w:0]   c_max_len  = (c_addr_w + 1)'(MAX_LEN);

  player_state_t       state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_cnt_w-1:0]  on_t_q, on_t_d;
  logic [c_cnt_w-1:0]  off_t_q, off_t_d;
  logic [c_addr_w-1:0] idx_q, idx_d;
  logic [c_addr_w:0]   step_q, step_d;
  logic [c_addr_w:0]   len_q, len_d;
  logic [c_ch_w-1:0]   chan_q, chan_d;
  logic                done_q, done_d;

  logic [c_cnt_w-1:0]  w_on_sh, w_off_sh, w_on_t, w_off_t;
  logic [c_addr_w:0]   w_len_eff, w_step_inc;
  logic [LED_W-1:0]    w_onehot;

  // Fast tempos can shift the base period to zero; a step never lasts less than one cycle.
  assign w_on_sh    = c_on_base >> bus_io.tempo_i;
  assign w_off_sh   = c_off_base >> bus_io.tempo_i;
  assign w_on_t     = (w_on_sh == '0) ? c_cnt_one : w_on_sh;
  assign w_off_t    = (w_off_sh == '0) ? c_cnt_one : w_off_sh;
  assign w_len_eff  = (bus_io.len_i > c_max_len) ? c_max_len : bus_io.len_i;
  assign w_step_inc = step_q + c_step_one;

  chan_decoder #(
    .N_CH  (N_CH),
    .LED_W (LED_W),
    .CH_W  (c_ch_w)
  ) u_dec (
    .idx_i    (chan_q),
    .onehot_o (w_onehot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      on_t_q  <= '0;
      off_t_q <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      chan_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      on_t_q  <= on_t_d;
      off_t_q <= off_t_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      len_q   <= len_d;
      chan_q  <= chan_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    on_t_d  = on_t_q;
    off_t_d = off_t_q;
    idx_d   = idx_q;
    step_d  = step_q;
    len_d   = len_q;
    chan_d  = chan_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus_io.start_i && !bus_io.abort_i) begin
          step_d  = '0;
          idx_d   = '0;
          on_t_d  = w_on_t;
          off_t_d = w_off_t;
          len_d   = w_len_eff;
          if (w_len_eff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LEAD;
            cnt_d   = w_off_t - c_cnt_one;
          end
        end
      end
      LEAD: begin
        if (cnt_q == '0) begin
          state_d = ON;
          cnt_d   = on_t_q - c_cnt_one;
          chan_d  = bus_io.rd_data_i;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      ON: begin
        if (cnt_q == '0) begin
          state_d = OFF;
          cnt_d   = off_t_q - c_cnt_one;
          step_d  = w_step_inc;
          // The index stops at the last step so the address never walks off the sequence.
          if (w_step_inc < len_q) begin
            idx_d = idx_q + c_idx_one;
          end
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      OFF: begin
        if (cnt_q == '0) begin
          if (step_q < len_q) begin
            state_d = ON;
            cnt_d   = on_t_q - c_cnt_one;
            chan_d  = bus_io.rd_data_i;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus_io.abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  assign bus_io.rd_addr_o = idx_q;
  assign bus_io.busy_o    = (state_q != IDLE);
  assign bus_io.done_o    = done_q;
  assign bus_io.step_o    = step_q;
  assign bus_io.led_out_o = (state_q == ON) ? w_onehot : '0;

endmodule
`default_nettype wire

// File: tb/tb_sequence_player.sv
`default_nettype none
// ============================================================================
// Module : tb_sequence_player
// Brief  : Self-checking bench for sequence_player against a timeline model.
// Rev    : 1.0
// ============================================================================
module tb_sequence_player;
  import simon_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sequence_player_if #(.ADDR_W(4), .CH_W(2), .LED_W(10)) if4 ();
  sequence_player_if #(.ADDR_W(4), .CH_W(2), .LED_W(10)) if3 ();

  sequence_player #(
    .N_CH(4), .MAX_LEN(16), .LED_W(10), .ON_CYC(8), .OFF_CYC(8)
  ) dut4 (
    .clk(clk), .reset(reset), .bus_io(if4)
  );

  sequence_player #(
    .N_CH(3), .MAX_LEN(16), .LED_W(10), .ON_CYC(8), .OFF_CYC(8)
  ) dut3 (
    .clk(clk), .reset(reset), .bus_io(if3)
  );

  logic [1:0] mem4 [16];
  logic [1:0] mem3 [16];

  // Sequence memories with one cycle of read latency.
  always @(posedge clk) begin
    if4.rd_data_i <= mem4[if4.rd_addr_o];
    if3.rd_data_i <= mem3[if3.rd_addr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model configuration for the run under check.
  bit m_on    = 1'b0;
  bit m_sel   = 1'b0;
  bit rst_chk = 1'b0;
  int m_k, m_L, m_on_t, m_off_t, m_ab, m_scn;
  int n_cmp = 0;
  int n_bad = 0;
  int peak  = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Expected outputs n cycles after the start was sampled, from the playback timeline.
  task automatic plain(input int n, output int led, output int busy, output int done,
                       output int step, output int addr, output bit av);
    int p, t, m, s, r, ch, nch;
    p = m_on_t + m_off_t;
    t = m_off_t + m_L * p;
    nch = m_sel ? 3 : 4;
    led = 0; busy = 0; done = 0; step = 0; addr = 0; av = 1'b1;
    if (m_L == 0) begin
      done = (n == 1) ? 1 : 0;
      av   = 1'b0;
    end else if (n <= m_off_t) begin
      busy = 1;
    end else if (n <= t) begin
      busy = 1;
      m = n - m_off_t - 1;
      s = m / p;
      r = m % p;
      if (r < m_on_t) begin
        ch   = m_sel ? int'(mem3[s]) : int'(mem4[s]);
        led  = (ch < nch) ? (1 << ch) : 0;
        step = s;
        addr = s;
      end else begin
        step = s + 1;
        addr = (s + 1 < m_L) ? s + 1 : m_L - 1;
      end
    end else begin
      done = (n == t + 1) ? 1 : 0;
      step = m_L;
      addr = m_L - 1;
    end
  endtask

  always @(negedge clk) begin
    int n, el, eb, ed, es, ea;
    bit eav;
    logic [9:0] al;
    logic       a_busy, a_done;
    logic [4:0] a_step;
    logic [3:0] a_addr;

    if (rst_chk) begin
      cmp("rst_led",  if4.led_out_o, 0);
      cmp("rst_busy", if4.busy_o, 0);
      cmp("rst_done", if4.done_o, 0);
      cmp("rst_step", if4.step_o, 0);
      cmp("rst_addr", if4.rd_addr_o, 0);
    end

    if (m_on) begin
      n = cyc - m_k + 1;
      if (m_ab > 0 && n > m_ab) begin
        plain(m_ab, el, eb, ed, es, ea, eav);
        el = 0; eb = 0; ed = 0; eav = 1'b0;
      end else begin
        plain(n, el, eb, ed, es, ea, eav);
      end
      al     = m_sel ? if3.led_out_o : if4.led_out_o;
      a_busy = m_sel ? if3.busy_o    : if4.busy_o;
      a_done = m_sel ? if3.done_o    : if4.done_o;
      a_step = m_sel ? if3.step_o    : if4.step_o;
      a_addr = m_sel ? if3.rd_addr_o : if4.rd_addr_o;
      cmp("led",  al, el);
      cmp("busy", a_busy, eb);
      cmp("done", a_done, ed);
      cmp("step", a_step, es);
      if (eav) cmp("rd_addr", a_addr, ea);
      if (n == 1) peak = 0;
      if (int'(a_addr) > peak) peak = int'(a_addr);

      case (m_scn)
        1: begin
          if (n == 9)  cmp("lit_step0_led", al, 32'h004);
          if (n == 17) cmp("lit_off0_led",  al, 32'h000);
          if (n == 25) cmp("lit_step1_led", al, 32'h001);
          if (n == 41) cmp("lit_step2_led", al, 32'h008);
          if (n == 56) cmp("lit_busy_last", a_busy, 1);
          if (n == 57) begin
            cmp("lit_done57", a_done, 1);
            cmp("lit_step57", a_step, 3);
          end
        end
        2: begin
          if (n == 3) cmp("lit_fast_led",  al, 32'h004);
          if (n == 7) cmp("lit_fast_done", a_done, 1);
        end
        3: begin
          if (n == 29) cmp("lit_abort_led",  al, 32'h000);
          if (n == 29) cmp("lit_abort_busy", a_busy, 0);
        end
        4: begin
          if (n == 1) cmp("lit_len0_done", a_done, 1);
          if (n == 2) cmp("lit_len0_busy", a_busy, 0);
        end
        5: begin
          if (n == 265) begin
            cmp("lit_len20_done", a_done, 1);
            cmp("lit_addr_peak", peak, 15);
          end
        end
        6: begin
          if (n == 12) cmp("lit_blank_led", al, 32'h000);
          if (n == 25) cmp("lit_nch3_led",  al, 32'h002);
          if (n == 41) cmp("lit_nch3_done", a_done, 1);
        end
        default: ;
      endcase
    end
  end

  task automatic at_n(input int n);
    while (cyc < m_k + n - 1) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  task automatic end_at(input int n);
    at_n(n + 1);
    m_on = 1'b0;
  endtask

  task automatic launch(input int len, input int tmp, input bit sel, input int scn);
    int on_s, off_s;
    @(posedge clk);
    #2;
    on_s    = 8 >> tmp;
    off_s   = 8 >> tmp;
    m_sel   = sel;
    m_L     = (len > 16) ? 16 : len;
    m_on_t  = (on_s < 1) ? 1 : on_s;
    m_off_t = (off_s < 1) ? 1 : off_s;
    m_ab    = 0;
    m_scn   = scn;
    if (sel) begin
      if3.start_i = 1'b1; if3.len_i = 5'(len); if3.tempo_i = 2'(tmp);
    end else begin
      if4.start_i = 1'b1; if4.len_i = 5'(len); if4.tempo_i = 2'(tmp);
    end
    @(posedge clk);
    #2;
    if3.start_i = 1'b0;
    if4.start_i = 1'b0;
    m_k  = cyc;
    m_on = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem3[i] = 2'd0;
    mem3[0] = 2'd3;
    mem3[1] = 2'd1;
    mem4 = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3,
             2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd2};
    if4.start_i = 1'b0; if4.abort_i = 1'b0; if4.len_i = '0; if4.tempo_i = '0;
    if3.start_i = 1'b0; if3.abort_i = 1'b0; if3.len_i = '0; if3.tempo_i = '0;
    reset   = 1'b1;
    rst_chk = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_chk = 1'b0;
    reset   = 1'b0;

    // Nominal three-step run.
    launch(3, 0, 1'b0, 1);
    end_at(60);

    // Tempo 2 quarters both periods.
    launch(1, 2, 1'b0, 2);
    end_at(10);

    // Abort during the second lamp, together with a start that must not restart.
    launch(3, 0, 1'b0, 3);
    at_n(28);
    if4.abort_i = 1'b1;
    if4.start_i = 1'b1;
    m_ab = 28;
    at_n(29);
    if4.abort_i = 1'b0;
    if4.start_i = 1'b0;
    end_at(40);
    launch(3, 0, 1'b0, 1);
    end_at(60);

    // Empty and over-long sequences.
    launch(0, 0, 1'b0, 4);
    end_at(6);
    launch(20, 0, 1'b0, 5);
    end_at(270);

    // Start pulses while busy, including the last busy cycle.
    launch(3, 0, 1'b0, 1);
    at_n(20);
    if4.start_i = 1'b1; if4.len_i = 5'd1; if4.tempo_i = 2'd3;
    at_n(21);
    if4.start_i = 1'b0;
    at_n(56);
    if4.start_i = 1'b1;
    at_n(57);
    if4.start_i = 1'b0; if4.len_i = 5'd3; if4.tempo_i = 2'd0;
    end_at(60);

    // Asynchronous reset between edges while a lamp is lit.
    launch(3, 0, 1'b0, 0);
    at_n(12);
    m_on = 1'b0;
    #1;
    reset   = 1'b1;
    rst_chk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_chk = 1'b0;
    reset   = 1'b0;

    // Three-lamp build: channel 3 is out of range and stays dark.
    launch(2, 0, 1'b1, 6);
    end_at(44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
